// File: rtl/noc2_mem_arb_pkg.sv
// Shared definitions for the NoC2 memory request arbiter: FSM encoding,
// header length field geometry and default flit width.
package noc2_mem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int LEN_W       = 8;
  localparam int LEN_LSB_DEF = 22;
  localparam int DATA_W_DEF  = 64;

endpackage

// File: rtl/noc2_mem_req_arb_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping modulo N; idx falls back to ptr when nothing requests.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W:0]   sum  [N];
  logic [W-1:0] cand [N];

  // Explicit compare-and-subtract keeps the wrap correct for non-power-of-two N.
  for (genvar gi = 0; gi < N; gi++) begin : g_cand
    assign sum[gi]  = {1'b0, ptr} + (W+1)'(gi);
    assign cand[gi] = (sum[gi] >= (W+1)'(N)) ? W'(sum[gi] - (W+1)'(N)) : sum[gi][W-1:0];
  end

  always_comb begin
    idx = ptr;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        idx = cand[k];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc2_mem_req_arb.sv
// Packet-level round-robin arbiter merging NUM_SRC NoC2 val/rdy streams onto one
// memory controller input. Optional per-source packet counters: FAKE_MEM_ARB_STATS_EN.
module noc2_mem_req_arb
  import noc2_mem_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 2,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LEN_LSB = LEN_LSB_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC*DATA_W-1:0] src_data_in,
  input  logic [NUM_SRC-1:0]        src_val_in,
  output logic [NUM_SRC-1:0]        src_rdy_out,
  output logic [DATA_W-1:0]         mc_data_out,
  output logic                      mc_val_out,
  input  logic                      mc_rdy_in,
  output logic [SRC_W-1:0]          grant_idx_out,
  output logic                      busy_out
`ifdef FAKE_MEM_ARB_STATS_EN
  ,
  output logic [NUM_SRC*32-1:0]     pkt_cnt_out
`endif
);

  arb_state_e       state_reg, state_next;
  logic [SRC_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [SRC_W-1:0] lock_idx_reg, lock_idx_next;
  logic [LEN_W-1:0] remaining_reg, remaining_next;

  logic [SRC_W-1:0] pick_idx;
  logic             pick_any;
  logic [SRC_W-1:0] selected;
  logic [SRC_W-1:0] sel_inc;
  logic             sel_val;
  logic             hs;
  logic [LEN_W-1:0] len;

  rr_pick #(
    .N (NUM_SRC),
    .W (SRC_W)
  ) u_rr_pick (
    .req (src_val_in),
    .ptr (rr_ptr_reg),
    .idx (pick_idx),
    .any (pick_any)
  );

  // While a packet is in flight the locked source owns the channel outright.
  assign selected = (state_reg == BURST) ? lock_idx_reg : pick_idx;
  assign sel_val  = (state_reg == BURST) ? src_val_in[lock_idx_reg] : pick_any;
  assign sel_inc  = (selected == SRC_W'(NUM_SRC - 1)) ? '0 : selected + 1'b1;
  assign hs       = mc_val_out & mc_rdy_in;
  assign len      = mc_data_out[LEN_LSB +: LEN_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      lock_idx_reg  <= '0;
      remaining_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      lock_idx_reg  <= lock_idx_next;
      remaining_reg <= remaining_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    lock_idx_next  = lock_idx_reg;
    remaining_next = remaining_reg;
    if (hs) begin
      case (state_reg)
        IDLE: begin
          if (len == '0) begin
            rr_ptr_next = sel_inc;
          end else begin
            state_next     = BURST;
            lock_idx_next  = selected;
            remaining_next = len;
          end
        end
        BURST: begin
          if (remaining_reg != '0) begin
            remaining_next = remaining_reg - 1'b1;
          end
          if (remaining_reg <= LEN_W'(1)) begin
            state_next  = IDLE;
            rr_ptr_next = sel_inc;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    mc_data_out   = src_data_in[selected*DATA_W +: DATA_W];
    mc_val_out    = sel_val & ~reset;
    grant_idx_out = reset ? '0 : selected;
    busy_out      = (state_reg == BURST) & ~reset;
    src_rdy_out   = '0;
    if (!reset && mc_rdy_in) begin
      src_rdy_out[selected] = 1'b1;
    end
  end

`ifdef FAKE_MEM_ARB_STATS_EN
  logic pkt_done;

  // A packet completes on a zero-length header or on the final payload flit.
  assign pkt_done = hs & (((state_reg == IDLE) & (len == '0)) |
                          ((state_reg == BURST) & (remaining_reg == LEN_W'(1))));

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cnt
    logic [31:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (pkt_done && (selected == SRC_W'(gi))) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
    assign pkt_cnt_out[gi*32 +: 32] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_noc2_mem_req_arb.sv
// Directed bench for noc2_mem_req_arb: cycle-by-cycle vector table plus hand-written
// packet sequences; checks counters when FAKE_MEM_ARB_STATS_EN is defined.
module tb_noc2_mem_req_arb;

  logic         clk;
  logic         reset;
  logic [255:0] src_data_in;
  logic [3:0]   src_val_in;
  logic [3:0]   src_rdy_out;
  logic [63:0]  mc_data_out;
  logic         mc_val_out;
  logic         mc_rdy_in;
  logic [1:0]   grant_idx_out;
  logic         busy_out;
`ifdef FAKE_MEM_ARB_STATS_EN
  logic [127:0] pkt_cnt_out;
`endif

  int total = 0;
  int bad   = 0;

  noc2_mem_req_arb dut (
    .clk           (clk),
    .reset         (reset),
    .src_data_in   (src_data_in),
    .src_val_in    (src_val_in),
    .src_rdy_out   (src_rdy_out),
    .mc_data_out   (mc_data_out),
    .mc_val_out    (mc_val_out),
    .mc_rdy_in     (mc_rdy_in),
    .grant_idx_out (grant_idx_out),
    .busy_out      (busy_out)
`ifdef FAKE_MEM_ARB_STATS_EN
    ,
    .pkt_cnt_out   (pkt_cnt_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] val;
    logic       rdy;
    logic [7:0] len;
    logic       ev;
    logic [1:0] eg;
    logic       eb;
    logic [3:0] erdy;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [63:0] make_data(input int src, input int tag, input logic [7:0] l);
    logic [7:0] t;
    t = 8'(tag);
    return (64'(l) << 22) | (64'(src) << 8) | 64'(t);
  endfunction

  function automatic void add(input logic rst, input logic [3:0] val, input logic rdy,
                              input logic [7:0] len, input logic ev, input logic [1:0] eg,
                              input logic eb, input logic [3:0] erdy);
    vec_t v;
    v.rst = rst; v.val = val; v.rdy = rdy; v.len = len;
    v.ev = ev; v.eg = eg; v.eb = eb; v.erdy = erdy;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [3:0] val, input logic rdy,
                       input logic [7:0] len, input int tag);
    reset      = rst;
    src_val_in = val;
    mc_rdy_in  = rdy;
    for (int i = 0; i < 4; i++) src_data_in[i*64 +: 64] = make_data(i, tag, len);
  endtask

  // Offers one flit from src and waits (bounded) for it to be accepted.
  task automatic send_flit(input int src, input logic [7:0] len, input int tag, input logic exp_busy);
    int n;
    n = 0;
    @(negedge clk);
    drive(1'b0, 4'(1 << src), 1'b1, len, tag);
    #1;
    while (!(mc_val_out && mc_rdy_in) && n < 8) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("hs_src%0d_t%0d", src, tag), 64'(mc_val_out & mc_rdy_in), 64'd1);
    chk($sformatf("grant_src%0d_t%0d", src, tag), 64'(grant_idx_out), 64'(src));
    chk($sformatf("busy_src%0d_t%0d", src, tag), 64'(busy_out), 64'(exp_busy));
    $display("flit src=%0d tag=%0d grant=%0d busy=%0b", src, tag, grant_idx_out, busy_out);
    @(posedge clk);
  endtask

  initial begin
    drive(1'b1, 4'b0, 1'b0, 8'd0, 0);

    // rst val rdy len | ev eg eb erdy
    add(1, 4'b1111, 1, 3, 0, 0, 0, 4'b0000);  // 0 reset with traffic offered
    add(1, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);  // 1
    add(0, 4'b0100, 1, 2, 1, 2, 0, 4'b0100);  // 2 src2 header len=2
    add(0, 4'b0100, 1, 0, 1, 2, 1, 4'b0100);  // 3 payload 1
    add(0, 4'b0100, 1, 0, 1, 2, 1, 4'b0100);  // 4 payload 2 (last)
    add(0, 4'b0000, 1, 0, 0, 3, 0, 4'b1000);  // 5 idle, rr_ptr=3
    add(0, 4'b1000, 1, 0, 1, 3, 0, 4'b1000);  // 6 src3 zero-length
    add(0, 4'b1001, 1, 0, 1, 0, 0, 4'b0001);  // 7 next grant src0
    add(1, 4'b1111, 1, 1, 0, 0, 0, 4'b0000);  // 8 reset
    add(0, 4'b1111, 1, 1, 1, 0, 0, 4'b0001);  // 9 contention: 0,1,2,3,0
    add(0, 4'b1111, 1, 1, 1, 0, 1, 4'b0001);  // 10
    add(0, 4'b1111, 1, 1, 1, 1, 0, 4'b0010);  // 11
    add(0, 4'b1111, 1, 1, 1, 1, 1, 4'b0010);  // 12
    add(0, 4'b1111, 1, 1, 1, 2, 0, 4'b0100);  // 13
    add(0, 4'b1111, 1, 1, 1, 2, 1, 4'b0100);  // 14
    add(0, 4'b1111, 1, 1, 1, 3, 0, 4'b1000);  // 15
    add(0, 4'b1111, 1, 1, 1, 3, 1, 4'b1000);  // 16
    add(0, 4'b1111, 1, 1, 1, 0, 0, 4'b0001);  // 17
    add(0, 4'b1111, 1, 1, 1, 0, 1, 4'b0001);  // 18
    add(0, 4'b0011, 1, 3, 1, 1, 0, 4'b0010);  // 19 src1 len=3, src0 waiting
    add(0, 4'b0011, 1, 0, 1, 1, 1, 4'b0010);  // 20 rdy=1
    add(0, 4'b0011, 0, 0, 1, 1, 1, 4'b0000);  // 21 rdy=0
    add(0, 4'b0011, 0, 0, 1, 1, 1, 4'b0000);  // 22 rdy=0
    add(0, 4'b0011, 1, 0, 1, 1, 1, 4'b0010);  // 23 rdy=1
    add(0, 4'b0011, 1, 0, 1, 1, 1, 4'b0010);  // 24 rdy=1, 4th flit
    add(0, 4'b0011, 1, 0, 1, 0, 0, 4'b0001);  // 25 src0 finally served
    add(1, 4'b0000, 1, 0, 0, 0, 0, 4'b0000);  // 26 reset
    add(0, 4'b0100, 1, 4, 1, 2, 0, 4'b0100);  // 27 src2 header len=4
    add(0, 4'b0100, 1, 0, 1, 2, 1, 4'b0100);  // 28 second flit
    add(1, 4'b0100, 1, 0, 0, 0, 0, 4'b0000);  // 29 reset mid-burst
    add(0, 4'b0101, 1, 0, 1, 0, 0, 4'b0001);  // 30 src0 from rr_ptr=0
    add(0, 4'b0100, 1, 0, 1, 2, 0, 4'b0100);  // 31 burst was aborted
    add(0, 4'b0010, 1, 2, 1, 1, 0, 4'b0010);  // 32 src1 len=2 from rr_ptr=3
    add(0, 4'b1000, 1, 0, 0, 1, 1, 4'b0010);  // 33 gap on locked source
    add(0, 4'b1010, 1, 0, 1, 1, 1, 4'b0010);  // 34
    add(0, 4'b1010, 1, 0, 1, 1, 1, 4'b0010);  // 35 last flit
    add(0, 4'b1000, 0, 0, 1, 3, 0, 4'b0000);  // 36 offered, not accepted
    add(0, 4'b0001, 0, 0, 1, 0, 0, 4'b0000);  // 37 selection moves freely

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k].rst, vecs[k].val, vecs[k].rdy, vecs[k].len, k);
      #2;
      chk($sformatf("v%0d_mc_val", k), 64'(mc_val_out), 64'(vecs[k].ev));
      chk($sformatf("v%0d_grant", k), 64'(grant_idx_out), 64'(vecs[k].eg));
      chk($sformatf("v%0d_busy", k), 64'(busy_out), 64'(vecs[k].eb));
      chk($sformatf("v%0d_src_rdy", k), 64'(src_rdy_out), 64'(vecs[k].erdy));
      if (!vecs[k].rst)
        chk($sformatf("v%0d_data", k), mc_data_out, make_data(int'(vecs[k].eg), k, vecs[k].len));
      $display("vec %0d rst=%0b val=%b rdy=%0b -> mc_val=%0b grant=%0d busy=%0b src_rdy=%b",
               k, vecs[k].rst, vecs[k].val, vecs[k].rdy, mc_val_out, grant_idx_out, busy_out, src_rdy_out);
    end

    // Packet sequence: 5 zero-length packets from src1, 2 one-flit packets from src3.
    @(negedge clk);
    drive(1'b1, 4'b0, 1'b1, 8'd0, 0);
    @(negedge clk);
    drive(1'b1, 4'b0, 1'b1, 8'd0, 0);
    for (int p = 0; p < 5; p++) send_flit(1, 8'd0, 100 + p, 1'b0);
    for (int p = 0; p < 2; p++) begin
      send_flit(3, 8'd1, 110 + 2*p, 1'b0);
      send_flit(3, 8'd0, 111 + 2*p, 1'b1);
    end
    @(negedge clk);
    drive(1'b0, 4'b0, 1'b1, 8'd0, 0);
    #1;
    chk("seq_idle_busy", 64'(busy_out), 64'd0);
    chk("seq_idle_rr_ptr", 64'(grant_idx_out), 64'd0);
`ifdef FAKE_MEM_ARB_STATS_EN
    chk("cnt_src0", 64'(pkt_cnt_out[0 +: 32]), 64'd0);
    chk("cnt_src1", 64'(pkt_cnt_out[32 +: 32]), 64'd5);
    chk("cnt_src2", 64'(pkt_cnt_out[64 +: 32]), 64'd0);
    chk("cnt_src3", 64'(pkt_cnt_out[96 +: 32]), 64'd2);
    @(negedge clk);
    drive(1'b1, 4'b0, 1'b1, 8'd0, 0);
    @(negedge clk);
    chk("cnt_src1_after_reset", 64'(pkt_cnt_out[32 +: 32]), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
